// File: rtl/serial_rcs.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one full-subtractor bit per clock, LSB first.
// The result and borrow-out are registered and held until the next operation completes.
module serial_rcs #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             in_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             brw_next;
    logic [WIDTH-1:0] d_shifted;

    assign d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    assign brw_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
    assign d_shifted = {d_bit, d_sh_q[WIDTH-1:1]};

    // Handshake: an operation is accepted on a rising edge where start_i = 1 and
    // in_ready_o = 1; operands are sampled only on that edge. done_o pulses for one
    // cycle when diff_o/bout_o update, and start_i in that cycle chains the next op.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    d_sh_d  = '0;
                    cnt_d   = '0;
                    brw_d   = bin_i;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = d_shifted;
                cnt_d  = cnt_q + CW'(1);
                brw_d  = brw_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = d_shifted;
                    bout_d  = brw_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready_o = (state_q != S_RUN);
    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign diff_o     = diff_q;
    assign bout_o     = bout_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_serial_rcs.sv
// Bench for serial_rcs: a WIDTH=3 and a WIDTH=8 instance checked every cycle against an
// arithmetic model of a - b - bin with a fixed WIDTH-edge latency, plus literal spot checks.
module tb_serial_rcs;

    logic        clk;
    logic        rst;
    logic        st[2];
    logic [15:0] av[2];
    logic [15:0] bv[2];
    logic        bi[2];
    logic        chk_en;
    int          total;
    int          bad;

    logic       rdy3, busy3, done3, bout3;
    logic [2:0] diff3;
    logic [1:0] dbg3;
    logic       rdy8, busy8, done8, bout8;
    logic [7:0] diff8;
    logic [1:0] dbg8;
    // {in_ready, busy, done, bout, diff zero-extended to 16 bits}
    logic [19:0] out_w[2];

    localparam int W[2] = '{3, 8};

    serial_rcs #(.WIDTH(3)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(st[0]),
        .a_i(av[0][2:0]), .b_i(bv[0][2:0]), .bin_i(bi[0]),
        .in_ready_o(rdy3), .busy_o(busy3), .done_o(done3),
        .diff_o(diff3), .bout_o(bout3), .state_o(dbg3)
    );

    serial_rcs #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(st[1]),
        .a_i(av[1][7:0]), .b_i(bv[1][7:0]), .bin_i(bi[1]),
        .in_ready_o(rdy8), .busy_o(busy8), .done_o(done8),
        .diff_o(diff8), .bout_o(bout8), .state_o(dbg8)
    );

    assign out_w[0] = {rdy3, busy3, done3, bout3, 13'd0, diff3};
    assign out_w[1] = {rdy8, busy8, done8, bout8, 8'd0, diff8};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // behavioural model: result is plain arithmetic, available WIDTH edges after acceptance
    int          m_left[2];
    logic        m_done[2];
    logic [15:0] m_diff[2];
    logic        m_bout[2];
    logic [15:0] m_pdiff[2];
    logic        m_pbout[2];
    logic [16:0] exp_q3[$];
    logic [16:0] exp_q8[$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [16:0] mask, val;
            mask = (17'd1 << W[i]) - 17'd1;
            if (rst) begin
                m_left[i] = 0;
                m_done[i] = 1'b0;
                m_diff[i] = '0;
                m_bout[i] = 1'b0;
                if (i == 0) exp_q3.delete(); else exp_q8.delete();
            end else if (m_left[i] == 0 && st[i]) begin
                val = ({1'b0, av[i]} & mask) - ({1'b0, bv[i]} & mask) - {16'd0, bi[i]};
                m_pdiff[i] = val[15:0] & mask[15:0];
                m_pbout[i] = val[W[i]];
                if (i == 0) exp_q3.push_back({m_pbout[i], m_pdiff[i]});
                else        exp_q8.push_back({m_pbout[i], m_pdiff[i]});
                m_left[i] = W[i];
                m_done[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_done[i] = 1'b1;
                    m_diff[i] = m_pdiff[i];
                    m_bout[i] = m_pbout[i];
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    end

    // scoreboard / compare process
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [19:0] e;
                logic [16:0] q;
                e = {m_left[i] == 0, m_left[i] != 0, m_done[i], m_bout[i], m_diff[i]};
                chk(i == 0 ? "cycle_w3" : "cycle_w8", {12'd0, out_w[i]}, {12'd0, e});
                if (out_w[i][17] === 1'b1) begin
                    if ((i == 0 ? exp_q3.size() : exp_q8.size()) == 0) begin
                        chk(i == 0 ? "sb_empty_w3" : "sb_empty_w8", 32'd1, 32'd0);
                    end else begin
                        q = (i == 0) ? exp_q3.pop_front() : exp_q8.pop_front();
                        chk(i == 0 ? "sb_w3" : "sb_w8", {15'd0, out_w[i][16:0]}, {15'd0, q});
                    end
                end
            end
        end
    end

    // driver: one operation with a single start pulse; ed < 0 skips the literal checks
    task automatic op(input int i, input int a, input int b, input int c, input int ed, input int eb);
        int n;
        @(negedge clk);
        st[i] = 1'b1; av[i] = 16'(a); bv[i] = 16'(b); bi[i] = c[0];
        @(negedge clk);
        st[i] = 1'b0;
        av[i] = 16'($urandom_range(0, 65535));
        bv[i] = 16'($urandom_range(0, 65535));
        bi[i] = 1'($urandom_range(0, 1));
        n = 0;
        while (out_w[i][17] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("done_timeout", 32'(n), 32'(W[i]));
        if (ed >= 0) begin
            chk("latency", 32'(n), 32'(W[i]));
            chk("lit_diff", {16'd0, out_w[i][15:0]}, 32'(ed));
            chk("lit_bout", {31'd0, out_w[i][16]}, 32'(eb));
        end
    endtask

    initial begin
        int prev, cyc, ndone;
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0; bi[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_w3", {12'd0, out_w[0]}, 32'h80000);
        chk("reset_w8", {12'd0, out_w[1]}, 32'h80000);
        rst = 1'b0;

        op(0, 5, 3, 0, 2, 0);
        op(0, 3, 5, 0, 6, 1);
        op(0, 0, 0, 1, 7, 1);
        op(0, 7, 0, 1, 6, 0);

        // start held high during RUN with different operands
        @(negedge clk);
        st[0] = 1'b1; av[0] = 16'd6; bv[0] = 16'd1; bi[0] = 1'b0;
        @(negedge clk);
        av[0] = 16'd0; bv[0] = 16'd7;
        @(negedge clk);
        chk("hold_prev_diff", {29'd0, diff3}, 32'd6);
        @(negedge clk);
        st[0] = 1'b0;
        chk("hold_prev_diff2", {29'd0, diff3}, 32'd6);
        @(negedge clk);
        chk("ign_done", {31'd0, done3}, 32'd1);
        chk("ign_diff", {29'd0, diff3}, 32'd5);
        chk("ign_bout", {31'd0, bout3}, 32'd0);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        chk("ign_single_done", 32'(ndone), 32'd0);

        // reset mid-operation
        @(negedge clk);
        st[0] = 1'b1; av[0] = 16'd4; bv[0] = 16'd1; bi[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {12'd0, out_w[0]}, 32'h80000);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);

        // back-to-back with start held high
        prev = -1; cyc = 0; ndone = 0;
        @(negedge clk);
        st[0] = 1'b1;
        while (ndone < 4 && cyc < 60) begin
            av[0] = 16'($urandom_range(0, 7));
            bv[0] = 16'($urandom_range(0, 7));
            bi[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (done3) begin
                if (prev >= 0) chk("b2b_period", 32'(cyc - prev), 32'd4);
                prev = cyc;
                ndone++;
            end
        end
        st[0] = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd4);

        // exhaustive sweep at WIDTH=3
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    op(0, a, b, c, -1, 0);

        // random sweep at WIDTH=8, with boundary operands pinned first
        op(1, 0, 255, 1, 0, 1);
        op(1, 255, 0, 0, 255, 0);
        op(1, 200, 100, 1, 99, 0);
        for (int k = 0; k < 100; k++)
            op(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), -1, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained_w3", 32'(exp_q3.size()), 32'd0);
        chk("sb_drained_w8", 32'(exp_q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
